alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Pipeline register stage directly downstream of the combinational ALU. It captures the ALU result, status flags {N,V,Z} and the destination-register tag, and holds them in a two-entry skid buffer with a valid/ready handshake toward writeback. It also provides a combinational forwarding lookup over held entries and a retire counter. Backpressure from writeback never creates a combinational path to the upstream ready.

## Interface
- DATA_W, 32, result width
- RD_W, 5, destination register index width
- CNT_W, 16, retire counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; equals (state != FULL), driven from registered state only
- in_result  in  DATA_W  ALU out
- in_status  in  3  ALU status {N,V,Z}
- in_rd  in  RD_W  destination register
- in_wb_en  in  1  entry writes a register
- flush  in  1  synchronous discard of all held entries
- out_valid  out  1  head entry present
- out_ready  in  1  writeback accepts head
- out_result  out  DATA_W  head result
- out_status  out  3  head status
- out_rd  out  RD_W  head destination
- out_wb_en  out  1  head write enable
- fwd_rs  in  RD_W  forwarding query register
- fwd_hit  out  1  a held entry will write fwd_rs
- fwd_data  out  DATA_W  forwarded value, 0 when no hit
- retire_cnt  out  CNT_W  count of head entries consumed

## Operation
- Storage: HEAD register (drives out_*) and SKID register. State: EMPTY, ONE (HEAD valid), FULL (HEAD+SKID valid).
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- EMPTY: accept -> ONE, HEAD<=in.
- ONE: accept&fire -> ONE, HEAD<=in; accept&!fire -> FULL, SKID<=in; !accept&fire -> EMPTY; neither -> hold.
- FULL: in_ready=0; fire -> ONE, HEAD<=SKID; else hold.
- out_valid = (state != EMPTY).
- Capture rule: stored wb_en = in_wb_en & (in_rd != 0); x0 writes are suppressed at capture.
- Result, status and rd are stored unmodified; no arithmetic in this stage.
- Forwarding (combinational): check SKID first (younger), then HEAD. Hit when the entry is valid, its stored wb_en is 1 and its rd == fwd_rs. fwd_data = the youngest hit's result, else 0. fwd_rs==0 never hits.
- retire_cnt increments by 1 on every fire and wraps from 2^CNT_W-1 to 0. It is cleared only by reset, not by flush.
- flush: next state EMPTY. An in_* entry offered in the flush cycle is dropped, even if in_ready=1. A fire in the flush cycle counts: retire_cnt increments. Flush has priority over all other transitions.

## Timing
- Reset (async assert, sync-safe deassert by system): state EMPTY, out_valid=0, in_ready=1, out_result=0, out_status=0, out_rd=0, out_wb_en=0, SKID cleared, retire_cnt=0, fwd_hit=0.
- Reset mid-operation discards all entries immediately and asynchronously.
- Latency: an entry accepted at edge N is presented on out_* after edge N, so out_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- Stall: out_ready dropping while in_valid stays high absorbs exactly one extra entry, then in_ready=0 from the next cycle.
- out_* are stable while out_valid=1 and out_ready=0; HEAD changes only on fire, flush or reset.
- in_ready depends only on registered state. fwd_* are the only combinational outputs and depend on fwd_rs and registered state.
- Ordering: FIFO. SKID always holds the younger entry.

## Test plan
- Reset, then in {result=0x0000_0005, status=3'b000, rd=3, wb_en=1} with out_ready=1 -> out_valid=1 one cycle later with the same values; retire_cnt=1 after the fire.
- out_ready=0, push A(rd=4, 0x11) then B(rd=4, 0x22) -> after the second edge in_ready=0. fwd_rs=4 gives fwd_hit=1, fwd_data=0x22. Release out_ready -> A then B emerge in order and in_ready returns to 1.
- Push {rd=0, wb_en=1, result=0xFFFF_FFFF} -> out_wb_en=0; fwd_rs=0 gives fwd_hit=0, fwd_data=0.
- State FULL, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, retire_cnt increments by 1, and the flush-cycle input never appears.
- Preload retire_cnt to 0xFFFF via 65535 fires, fire once more -> retire_cnt=0x0000.
- Assert rst_n=0 asynchronously between edges while FULL -> out_valid and fwd_hit drop to 0 without a clock edge; in_ready=1.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result register stage behind the ALU: two-entry skid buffer toward writeback,
// combinational forwarding lookup over held entries, and a retire counter.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | HEAD holds the only entry
// FULL  | HEAD holds the older entry, SKID the younger; upstream stalled
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_status,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_status,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  input  logic [RD_W-1:0]   fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic [DATA_W-1:0]   skid_result;
  logic [2:0]          skid_status;
  logic [RD_W-1:0]     skid_rd;
  logic                skid_wb_en;

  logic accept;
  logic fire;
  logic in_wb_capt;
  logic head_hit;
  logic skid_hit;

  assign in_ready   = (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign accept     = in_valid & in_ready;
  assign fire       = out_valid & out_ready;
  // Writes to x0 are dropped here so neither writeback nor forwarding sees them.
  assign in_wb_capt = in_wb_en & (in_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_result  <= '0;
      out_status  <= '0;
      out_rd      <= '0;
      out_wb_en   <= 1'b0;
      skid_result <= '0;
      skid_status <= '0;
      skid_rd     <= '0;
      skid_wb_en  <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      if (fire) retire_cnt <= retire_cnt + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state      <= ONE;
              out_result <= in_result;
              out_status <= in_status;
              out_rd     <= in_rd;
              out_wb_en  <= in_wb_capt;
            end
          end
          ONE: begin
            if (accept && fire) begin
              out_result <= in_result;
              out_status <= in_status;
              out_rd     <= in_rd;
              out_wb_en  <= in_wb_capt;
            end else if (accept) begin
              state       <= FULL;
              skid_result <= in_result;
              skid_status <= in_status;
              skid_rd     <= in_rd;
              skid_wb_en  <= in_wb_capt;
            end else if (fire) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (fire) begin
              state      <= ONE;
              out_result <= skid_result;
              out_status <= skid_status;
              out_rd     <= skid_rd;
              out_wb_en  <= skid_wb_en;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // SKID is the younger entry, so it wins when both match.
  assign skid_hit = (state == FULL) && skid_wb_en && (skid_rd == fwd_rs) && (fwd_rs != '0);
  assign head_hit = (state != EMPTY) && out_wb_en && (out_rd == fwd_rs) && (fwd_rs != '0);
  assign fwd_hit  = skid_hit | head_hit;
  assign fwd_data = skid_hit ? skid_result : (head_hit ? out_result : '0);

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic checked
// against a queue-based model of the two-entry buffer.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [2:0]  in_status = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wb_en = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_status;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [4:0]  fwd_rs = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [15:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  status;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcnt = '0;

  alu_result_stage #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_status(in_status), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_status(out_status), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].wb && mq[i].rd == rs) begin
          hit = 1'b1;
          d   = mq[i].result;
        end
  endfunction

  task automatic compare_all();
    logic        h;
    logic [31:0] d;
    check("in_ready", in_ready, mq.size() < 2);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_result", out_result, mq[0].result);
      check("out_status", out_status, mq[0].status);
      check("out_rd", out_rd, mq[0].rd);
      check("out_wb_en", out_wb_en, mq[0].wb);
    end
    fwd_model(fwd_rs, h, d);
    check("fwd_hit", fwd_hit, h);
    check("fwd_data", fwd_data, d);
    check("retire_cnt", retire_cnt, mcnt);
  endtask

  task automatic model_update();
    bit   acc, fir;
    ent_t e;
    acc = in_valid && (mq.size() < 2);
    fir = out_ready && (mq.size() != 0);
    if (fir) mcnt = mcnt + 16'd1;
    if (flush) begin
      mq.delete();
    end else begin
      if (fir) void'(mq.pop_front());
      if (acc) begin
        e.result = in_result;
        e.status = in_status;
        e.rd     = in_rd;
        e.wb     = in_wb_en && (in_rd != 0);
        mq.push_back(e);
      end
    end
  endtask

  // Called aligned to a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    compare_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] r, input logic [2:0] s,
                       input logic [4:0] rd, input bit wb);
    in_valid  = v;
    in_result = r;
    in_status = s;
    in_rd     = rd;
    in_wb_en  = wb;
  endtask

  initial begin
    logic [15:0] c0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_result", out_result, 32'h0);
    check("rst out_status", out_status, 3'b000);
    check("rst out_rd", out_rd, 5'd0);
    check("rst out_wb_en", out_wb_en, 1'b0);
    check("rst retire_cnt", retire_cnt, 16'h0);
    check("rst fwd_hit", fwd_hit, 1'b0);

    // single entry passes through with one cycle latency
    out_ready = 1'b1;
    drive(1, 32'h5, 3'b000, 5'd3, 1);
    cycle();
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    #1;
    check("t1 out_valid", out_valid, 1'b1);
    check("t1 out_result", out_result, 32'h5);
    check("t1 out_rd", out_rd, 5'd3);
    check("t1 out_wb_en", out_wb_en, 1'b1);
    cycle();
    check("t1 retire_cnt", retire_cnt, 16'd1);

    // stall absorbs one extra entry, forwarding picks the younger one
    out_ready = 1'b0;
    drive(1, 32'h11, 3'b001, 5'd4, 1);
    cycle();
    drive(1, 32'h22, 3'b010, 5'd4, 1);
    cycle();
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    fwd_rs = 5'd4;
    #1;
    check("t2 in_ready", in_ready, 1'b0);
    check("t2 fwd_hit", fwd_hit, 1'b1);
    check("t2 fwd_data", fwd_data, 32'h22);
    check("t2 head A", out_result, 32'h11);
    out_ready = 1'b1;
    cycle();
    check("t2 head B", out_result, 32'h22);
    check("t2 in_ready back", in_ready, 1'b1);
    cycle();
    check("t2 drained", out_valid, 1'b0);

    // x0 writes are suppressed
    out_ready = 1'b0;
    drive(1, 32'hFFFF_FFFF, 3'b100, 5'd0, 1);
    cycle();
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    fwd_rs = 5'd0;
    #1;
    check("t3 out_wb_en", out_wb_en, 1'b0);
    check("t3 fwd_hit", fwd_hit, 1'b0);
    check("t3 fwd_data", fwd_data, 32'h0);
    out_ready = 1'b1;
    cycle();

    // flush while FULL drops everything including the offered entry, fire still counts
    out_ready = 1'b0;
    drive(1, 32'hA1, 3'b000, 5'd6, 1);
    cycle();
    drive(1, 32'hA2, 3'b000, 5'd6, 1);
    cycle();
    c0 = retire_cnt;
    drive(1, 32'hDEAD_BEEF, 3'b111, 5'd7, 1);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    #1;
    check("t4 out_valid", out_valid, 1'b0);
    check("t4 in_ready", in_ready, 1'b1);
    check("t4 retire_cnt", retire_cnt, c0 + 16'd1);
    cycle();
    check("t4 dropped", out_valid, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom, 3'($urandom_range(7, 0)),
            5'($urandom_range(7, 0)), $urandom_range(1, 0) == 1);
      out_ready = $urandom_range(1, 0) == 1;
      flush     = $urandom_range(15, 0) == 0;
      fwd_rs    = 5'($urandom_range(7, 0));
      cycle();
    end
    flush = 1'b0;

    // stream until the counter sits at its maximum, then wrap it
    out_ready = 1'b1;
    for (int i = 0; i < 70000 && mcnt != 16'hFFFF; i++) begin
      drive(1, $urandom, 3'b000, 5'($urandom_range(31, 0)), 1);
      cycle();
    end
    drive(1, 32'h77, 3'b000, 5'd2, 1);
    #1;
    check("wrap at max", retire_cnt, 16'hFFFF);
    check("wrap head present", out_valid, 1'b1);
    cycle();
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    #1;
    check("wrap to zero", retire_cnt, 16'h0000);
    cycle();

    // asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1, 32'hB1, 3'b000, 5'd9, 1);
    cycle();
    drive(1, 32'hB2, 3'b000, 5'd9, 1);
    cycle();
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    fwd_rs = 5'd9;
    #1;
    check("ar full", in_ready, 1'b0);
    check("ar fwd before", fwd_hit, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar out_valid", out_valid, 1'b0);
    check("ar fwd_hit", fwd_hit, 1'b0);
    check("ar in_ready", in_ready, 1'b1);
    check("ar retire_cnt", retire_cnt, 16'h0);
    mq.delete();
    mcnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
